// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// The grant encoding is one-hot and is derived from the arbiter state.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

    function automatic logic [1:0] state_to_grant(input arb_state_t s);
        logic [1:0] g;
        case (s)
            ARB_GRANT0: g = 2'b01;
            ARB_GRANT1: g = 2'b10;
            default:    g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone B4 bus bundle.
// The master modport drives the request side; the slave modport drives the response side.
interface wshb_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_ms;
    logic [DW-1:0]   dat_sm;
    logic [DW/8-1:0] sel;
    logic            we;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            stb;
    logic            cyc;
    logic            ack;
    logic            err;
    logic            rty;

    modport master (
        output adr, dat_ms, sel, we, cti, bte, stb, cyc,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  adr, dat_ms, sel, we, cti, bte, stb, cyc,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/wshb_arb_fsm.sv
// Round-robin ownership FSM for the two-master arbiter.
// Tracks the tenure ack count so a streaming owner is pre-empted on an ack boundary.
module wshb_arb_fsm
    import wshb_arb_pkg::*;
#(
    parameter int MAX_BURST = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cyc0,
    input  logic       cyc1,
    input  logic       ack,
    output arb_state_t state,
    output logic [1:0] grant
);

    localparam int CNT_WIDTH = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_BURST - 1);

    arb_state_t           state_q, state_d;
    arb_state_t           other_state;
    logic [1:0]           grant_q, grant_d;
    logic                 last_served_q, last_served_d;
    logic [CNT_WIDTH-1:0] ack_cnt_q, ack_cnt_d;
    logic                 own_cyc;
    logic                 other_cyc;

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        ack_cnt_d     = ack_cnt_q;
        own_cyc       = (state_q == ARB_GRANT1) ? cyc1 : cyc0;
        other_cyc     = (state_q == ARB_GRANT1) ? cyc0 : cyc1;
        other_state   = (state_q == ARB_GRANT1) ? ARB_GRANT0 : ARB_GRANT1;

        case (state_q)
            ARB_IDLE: begin
                if (cyc0 && cyc1) begin
                    state_d = last_served_q ? ARB_GRANT0 : ARB_GRANT1;
                end else if (cyc0) begin
                    state_d = ARB_GRANT0;
                end else if (cyc1) begin
                    state_d = ARB_GRANT1;
                end
            end
            ARB_GRANT0, ARB_GRANT1: begin
                // Release wins over pre-emption; the counter saturates while nobody else waits.
                if (!own_cyc) begin
                    state_d = other_cyc ? other_state : ARB_IDLE;
                end else if (ack) begin
                    if (ack_cnt_q == CNT_LAST) begin
                        if (other_cyc) begin
                            state_d = other_state;
                        end
                    end else begin
                        ack_cnt_d = ack_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        if (state_d != state_q) begin
            ack_cnt_d = '0;
            if (state_d == ARB_GRANT0) begin
                last_served_d = 1'b0;
            end else if (state_d == ARB_GRANT1) begin
                last_served_d = 1'b1;
            end
        end

        grant_d = state_to_grant(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            grant_q       <= 2'b00;
            last_served_q <= 1'b1;
            ack_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
            ack_cnt_q     <= ack_cnt_d;
        end
    end

    assign state = state_q;
    assign grant = grant_q;

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master, one-slave Wishbone arbiter sharing the SDRAM framebuffer port
// between the VGA reader (master 0) and the pattern generator (master 1).
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int MAX_BURST = 64
) (
    input  logic       clk,
    input  logic       rst,
    wshb_if.slave      wshb_ifs0,
    wshb_if.slave      wshb_ifs1,
    wshb_if.master     wshb_ifm,
    output logic [1:0] grant
);

    arb_state_t state;

    wshb_arb_fsm #(
        .MAX_BURST(MAX_BURST)
    ) u_fsm (
        .clk  (clk),
        .rst  (rst),
        .cyc0 (wshb_ifs0.cyc),
        .cyc1 (wshb_ifs1.cyc),
        .ack  (wshb_ifm.ack),
        .state(state),
        .grant(grant)
    );

    // Request path follows the registered owner; nothing reaches the slave while idle.
    always_comb begin
        wshb_ifm.adr    = '0;
        wshb_ifm.dat_ms = '0;
        wshb_ifm.sel    = '0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.cti    = '0;
        wshb_ifm.bte    = '0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.cyc    = 1'b0;
        case (state)
            ARB_GRANT0: begin
                wshb_ifm.adr    = wshb_ifs0.adr;
                wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
                wshb_ifm.sel    = wshb_ifs0.sel;
                wshb_ifm.we     = wshb_ifs0.we;
                wshb_ifm.cti    = wshb_ifs0.cti;
                wshb_ifm.bte    = wshb_ifs0.bte;
                wshb_ifm.stb    = wshb_ifs0.stb;
                wshb_ifm.cyc    = wshb_ifs0.cyc;
            end
            ARB_GRANT1: begin
                wshb_ifm.adr    = wshb_ifs1.adr;
                wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
                wshb_ifm.sel    = wshb_ifs1.sel;
                wshb_ifm.we     = wshb_ifs1.we;
                wshb_ifm.cti    = wshb_ifs1.cti;
                wshb_ifm.bte    = wshb_ifs1.bte;
                wshb_ifm.stb    = wshb_ifs1.stb;
                wshb_ifm.cyc    = wshb_ifs1.cyc;
            end
            default: ;
        endcase
    end

    always_comb begin
        wshb_ifs0.ack = (state == ARB_GRANT0) && wshb_ifm.ack;
        wshb_ifs0.err = (state == ARB_GRANT0) && wshb_ifm.err;
        wshb_ifs0.rty = (state == ARB_GRANT0) && wshb_ifm.rty;
        wshb_ifs1.ack = (state == ARB_GRANT1) && wshb_ifm.ack;
        wshb_ifs1.err = (state == ARB_GRANT1) && wshb_ifm.err;
        wshb_ifs1.rty = (state == ARB_GRANT1) && wshb_ifm.rty;
    end

    assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

endmodule
